pc_sequencer: RTL

- Control-side counterpart of the program counter: consumes the current PC and per-instruction flow requests, and drives the PC's pc_inc / pc_load / pc_next inputs.
- Holds a hardware return-address stack for CALL/RET and a small run/halt state machine.
- Sits between the instruction decoder and the program counter in the uC_8bits core.

---
 rtl/uc_pkg.sv | 24 ++
 rtl/return_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the uC_8bits control path.
// Contents: flow-request op encodings, sequencer state encoding and the
// default program-counter address width.
package uc_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;

    // Flow-request opcodes presented by the instruction decoder.
    // Encodings 6 and 7 are unused and behave as OP_NEXT.
    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HALT   = 3'd5
    } op_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO used by pc_sequencer for CALL/RET.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears count and entries)
//   push, pop       push din / drop top entry; ignored when full / empty
//   din             return address to push
//   dout            current top entry (combinational), 0 when empty
//   count           occupancy, 0..STACK_DEPTH
//   full, empty     occupancy status
module return_stack #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        din,
    output logic [ADDR_WIDTH-1:0]        dout,
    output logic [$clog2(STACK_DEPTH):0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0]         count_reg;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         top_idx;
    logic [ADDR_WIDTH-1:0] entries [STACK_DEPTH];

    assign full    = (count_reg == CW'(STACK_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // When not full, count never exceeds STACK_DEPTH-1, so its low bits
    // address the next free slot directly.
    assign wr_idx  = count_reg[IW-1:0];
    assign top_idx = IW'(count_reg - CW'(1));
    assign dout    = empty ? '0 : entries[top_idx];

    // Entries live in individual registers so reset can clear all of them.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            logic [ADDR_WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && !full && (wr_idx == IW'(gi))) begin
                    entry_reg <= din;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns decoder flow requests into the program
// counter's pc_inc / pc_load / pc_next controls, maintains a return-address
// stack for CALL/RET and a RUN/HALTED state machine.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_cur                   current PC
//   req_valid, req_op        flow request and opcode (uc_pkg::op_t)
//   req_target, cond_true    destination address, branch condition
//   stall                    freeze: request ignored, no PC or stack change
//   resume                   leave HALTED
//   pc_inc, pc_load, pc_next combinational controls to the program counter
//   running                  1 while in RUN
//   sp                       stack occupancy
//   stack_ovf, stack_unf     sticky fault flags, cleared only by rst
// Build option: define STACK_FAULT_HALT_EN to make a stack overflow or
// underflow suppress the PC change and halt the sequencer.
module pc_sequencer
    import uc_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int STACK_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        pc_cur,
    input  logic                         req_valid,
    input  logic [2:0]                   req_op,
    input  logic [ADDR_WIDTH-1:0]        req_target,
    input  logic                         cond_true,
    input  logic                         stall,
    input  logic                         resume,
    output logic                         pc_inc,
    output logic                         pc_load,
    output logic [ADDR_WIDTH-1:0]        pc_next,
    output logic                         running,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         stack_ovf,
    output logic                         stack_unf
);

    state_t                state_reg;
    logic                  stack_ovf_reg;
    logic                  stack_unf_reg;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  ovf_event;
    logic                  unf_event;
    logic                  halt_op;
    logic                  st_full;
    logic                  st_empty;
    logic [ADDR_WIDTH-1:0] st_top;
    logic [ADDR_WIDTH-1:0] ret_addr;

    assign accept    = req_valid && !stall && (state_reg == ST_RUN);
    assign ret_addr  = pc_cur + ADDR_WIDTH'(1);   // wraps at all-ones
    assign running   = (state_reg == ST_RUN);
    assign stack_ovf = stack_ovf_reg;
    assign stack_unf = stack_unf_reg;

    return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (st_top),
        .count (sp),
        .full  (st_full),
        .empty (st_empty)
    );

    // Op decode: zero-latency PC controls plus stack and fault strobes.
    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_next   = '0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        halt_op   = 1'b0;
        if (accept) begin
            case (req_op)
                OP_JUMP: begin
                    pc_load = 1'b1;
                    pc_next = req_target;
                end
                OP_BRANCH: begin
                    if (cond_true) begin
                        pc_load = 1'b1;
                        pc_next = req_target;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (st_full) begin
                        ovf_event = 1'b1;
`ifndef STACK_FAULT_HALT_EN
                        pc_load = 1'b1;
                        pc_next = req_target;
`endif
                    end else begin
                        push    = 1'b1;
                        pc_load = 1'b1;
                        pc_next = req_target;
                    end
                end
                OP_RET: begin
                    if (st_empty) begin
                        // pc_next stays 0 on underflow.
                        unf_event = 1'b1;
`ifndef STACK_FAULT_HALT_EN
                        pc_load = 1'b1;
`endif
                    end else begin
                        pop     = 1'b1;
                        pc_load = 1'b1;
                        pc_next = st_top;
                    end
                end
                OP_HALT: begin
                    halt_op = 1'b1;
                end
                default: begin
                    pc_inc = 1'b1;
                end
            endcase
        end
    end

    // Run/halt FSM and sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            stack_ovf_reg <= 1'b0;
            stack_unf_reg <= 1'b0;
        end else begin
            if (ovf_event) begin
                stack_ovf_reg <= 1'b1;
            end
            if (unf_event) begin
                stack_unf_reg <= 1'b1;
            end
            case (state_reg)
                ST_RUN: begin
`ifdef STACK_FAULT_HALT_EN
                    if (halt_op || ovf_event || unf_event) begin
                        state_reg <= ST_HALTED;
                    end
`else
                    if (halt_op) begin
                        state_reg <= ST_HALTED;
                    end
`endif
                end
                default: begin
                    if (resume) begin
                        state_reg <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule
